// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared definitions for the shift job sequencer: default parameter values,
// the width of the settle counter and the controller state encoding.
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

    localparam int W_DEF     = 4;   // shifter data width
    localparam int CNT_W_DEF = 4;   // shift-count field width
    localparam int LAT_DEF   = 1;   // settle cycles before so is captured
    localparam int LAT_W     = 4;   // settle counter width (LAT up to 15)

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/shift_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_ctrl_if
// Command/response handshake bundle between the system bus logic (master)
// and the shift sequencer (slave).
//   cmd_valid/cmd_ready/cmd_data/cmd_count : job request channel
//   rsp_valid/rsp_ready/rsp_data           : result channel
// -----------------------------------------------------------------------------
interface shift_ctrl_if
    import shift_ctrl_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [W-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;

    modport master (
        output cmd_valid, cmd_data, cmd_count, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_count, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_ctrl_down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Loadable down counter with zero/one flags. Decrement saturates at zero so a
// stray enable can never wrap the count.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over en)
//   en        : decrement by one
//   is_zero   : count == 0
//   is_one    : count == 1 (last cycle of a run)
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             is_zero,
    output logic             is_one
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);
    assign is_one  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/shift_ctrl.sv
// -----------------------------------------------------------------------------
// shift_ctrl
// Runs complete shift jobs on the external shifter: accepts {word, count},
// clears the shifter, shifts for exactly count cycles, waits LAT settle
// cycles, captures so and returns it on the response channel.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : cmd_valid/ready/data/count in, rsp_valid/ready/data out
//   busy          : high in every state except IDLE
//   sh_rst/sh_shn : shifter reset and shift-enable
//   sh_si / sh_so : shifter data in / out
// Every output is decoded from registered state; nothing on the command or
// response inputs reaches an output combinationally.
// -----------------------------------------------------------------------------
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    shift_ctrl_if.slave  bus,
    output logic         busy,
    output logic         sh_rst,
    output logic         sh_shn,
    output logic [W-1:0] sh_si,
    input  logic [W-1:0] sh_so
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_CLEAR  = CLEAR;
    localparam logic [2:0] S_SHIFT  = SHIFT;
    localparam logic [2:0] S_SETTLE = SETTLE;
    localparam logic [2:0] S_RESP   = RESP;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;

    logic shift_load, shift_en, shift_zero, shift_one;
    logic settle_load, settle_en, settle_zero, settle_one;

    down_counter #(.WIDTH(CNT_W)) u_shift_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (shift_load),
        .en       (shift_en),
        .load_val (bus.cmd_count),
        .is_zero  (shift_zero),
        .is_one   (shift_one)
    );

    down_counter #(.WIDTH(LAT_W)) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .en       (settle_en),
        .load_val (LAT_W'(LAT)),
        .is_zero  (settle_zero),
        .is_one   (settle_one)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        shift_load  = 1'b0;
        shift_en    = 1'b0;
        settle_load = 1'b0;
        settle_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    data_d     = bus.cmd_data;
                    shift_load = 1'b1;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // A zero-length job skips SHIFT and samples the cleared shifter.
                settle_load = shift_zero;
                state_d     = shift_zero ? S_SETTLE : S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                // Exit on the last shift; the zero term only guards a count
                // that somehow reached zero inside SHIFT.
                if (shift_one || shift_zero) begin
                    settle_load = 1'b1;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_en = 1'b1;
                if (settle_one || settle_zero) begin
                    rsp_data_d = sh_so;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; a reset mid-job
        // therefore drops the job at the next edge, discarding its result.
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            state_q    <= state_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != S_IDLE);
    // The shifter is held in reset for as long as the controller is.
    assign sh_rst        = rst || (state_q == S_CLEAR);
    assign sh_shn        = (state_q == S_SHIFT);
    assign sh_si         = ((state_q == S_SHIFT) || (state_q == S_SETTLE)) ? data_q : '0;

endmodule
